// File: rtl/gather_queue.sv
// rtl/gather_queue.sv - compacting multi-lane FIFO with a dense oldest-first output window
module gather_queue #(
  parameter int DATA  = 32,
  parameter int IN    = 4,
  parameter int OUT   = 4,
  parameter int DEPTH = 16,
  parameter bit ACT   = 1'b1,
  localparam int PW   = $clog2(OUT + 1),
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     flush,
  input  logic [IN-1:0]            in_valid,
  input  logic [IN-1:0][DATA-1:0]  in,
  output logic                     in_ready,
  output logic [OUT-1:0]           out_valid,
  output logic [OUT-1:0][DATA-1:0] out,
  input  logic [PW-1:0]            pop,
  output logic [CW-1:0]            count
);

  logic [DATA-1:0] storage [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [IN-1:0]   lane_act;
  logic [AW-1:0]   lane_off [IN];
  logic [CW-1:0]   nin;
  logic            push;
  logic [CW-1:0]   pop_eff;

  // Decode active lanes and give each one its packed slot offset (active lanes below it).
  always_comb begin
    nin      = '0;
    lane_act = '0;
    lane_off = '{default: '0};
    for (int i = 0; i < IN; i++) begin
      lane_act[i] = (in_valid[i] == ACT);
      lane_off[i] = AW'(nin);
      if (lane_act[i]) nin = nin + CW'(1);
    end
  end

  // Room for a whole IN-lane push is judged on registered occupancy only, so pop cannot raise it.
  assign in_ready = (CW'(DEPTH) - count) >= CW'(IN);
  assign push     = in_ready && (nin != '0);

  // Clamp the requested pop to what is both present and visible in the window.
  always_comb begin
    pop_eff = CW'(pop);
    if (pop_eff > count) pop_eff = count;
    if (pop_eff > CW'(OUT)) pop_eff = CW'(OUT);
  end

  // Pointer and occupancy registers; flush discards any push/pop of its cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_eff);
      if (push) tail <= tail + AW'(nin);
      count <= count + (push ? nin : '0) - pop_eff;
    end
  end

  // Write active lanes densely from tail; indices wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      for (int i = 0; i < IN; i++) begin
        if (lane_act[i]) storage[tail + lane_off[i]] <= in[i];
      end
    end
  end

  // Present the oldest entries; lanes beyond the occupancy are zeroed so stale storage never leaks.
  always_comb begin
    out_valid = {OUT{~ACT}};
    out       = '0;
    for (int k = 0; k < OUT; k++) begin
      if (CW'(k) < count) begin
        out_valid[k] = ACT;
        out[k]       = storage[head + AW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_gather_queue.sv
// tb/tb_gather_queue.sv - directed and random checks of gather_queue against a queue model
module tb_gather_queue;

  logic             clk;
  logic             reset_;
  logic             flush;
  logic [3:0]       in_valid;
  logic [3:0][31:0] din;
  logic             in_ready;
  logic [3:0]       out_valid;
  logic [3:0][31:0] dout;
  logic [2:0]       pop;
  logic [4:0]       count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;
  logic [31:0] mq [$];

  gather_queue #(.DATA(32), .IN(4), .OUT(4), .DEPTH(16), .ACT(1'b1)) dut (
    .clk(clk), .reset_(reset_), .flush(flush), .in_valid(in_valid), .in(din),
    .in_ready(in_ready), .out_valid(out_valid), .out(dout), .pop(pop), .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Queue-level model: clamp pop, drop whole push if fewer than 4 free slots, append lanes in order.
  task automatic model_step();
    int pe;
    bit rdy;
    if (flush) begin
      mq.delete();
      return;
    end
    rdy = (16 - mq.size()) >= 4;
    pe = int'(pop);
    if (pe > mq.size()) pe = mq.size();
    if (pe > 4) pe = 4;
    for (int i = 0; i < pe; i++) void'(mq.pop_front());
    if (rdy) begin
      for (int i = 0; i < 4; i++) if (in_valid[i]) mq.push_back(din[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    din = '0;
    pop = '0;
    flush = 1'b0;
  endtask

  task automatic push_full(input logic [31:0] base);
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) din[i] = base + 32'(i);
    tick();
    idle();
  endtask

  task automatic do_pop(input logic [2:0] p);
    pop = p;
    tick();
    idle();
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_out%0d", tag, k), dout[k], 32'd0);
  endtask

  // Every mid-cycle sample, the DUT must show the model's oldest entries.
  always @(negedge clk) begin
    if (chk_on && reset_) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_ready", 32'(in_ready), ((16 - mq.size()) >= 4) ? 32'd1 : 32'd0);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("m_valid%0d", k), 32'(out_valid[k]), (k < mq.size()) ? 32'd1 : 32'd0);
        chk($sformatf("m_out%0d", k), dout[k], (k < mq.size()) ? mq[k] : 32'd0);
      end
    end
  end

  initial begin
    reset_ = 1'b1;
    idle();
    #2 reset_ = 1'b0;
    #1 reset_literals("rst");
    @(posedge clk);
    #3 reset_ = 1'b1;
    mq.delete();
    chk_on = 1;

    // sparse compaction
    in_valid = 4'b1010;
    din[1] = 32'hA;
    din[3] = 32'hB;
    tick();
    idle();
    chk("sp_count", 32'(count), 32'd2);
    chk("sp_out0", dout[0], 32'hA);
    chk("sp_out1", dout[1], 32'hB);
    chk("sp_valid", 32'(out_valid), 32'h3);
    chk("sp_out2", dout[2], 32'd0);
    chk("sp_out3", dout[3], 32'd0);
    do_pop(3'd2);
    chk("sp_empty", 32'(count), 32'd0);

    // fill, dropped push, pop
    for (int j = 0; j < 4; j++) push_full(32'(4 * j));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ready", 32'(in_ready), 32'd0);
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) din[i] = 32'hFF;
    tick();
    idle();
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_out3", dout[3], 32'd3);
    do_pop(3'd4);
    chk("fp_count", 32'(count), 32'd12);
    for (int k = 0; k < 4; k++) chk($sformatf("fp_out%0d", k), dout[k], 32'(4 + k));
    chk("fp_ready", 32'(in_ready), 32'd1);
    for (int j = 0; j < 3; j++) do_pop(3'd4);
    chk("drain_count", 32'(count), 32'd0);

    // simultaneous push/pop and clamping
    push_full(32'd100);
    in_valid = 4'b0100;
    din[2] = 32'd200;
    tick();
    idle();
    chk("sim_c5", 32'(count), 32'd5);
    in_valid = 4'b0111;
    for (int i = 0; i < 4; i++) din[i] = 32'(210 + i);
    pop = 3'd2;
    tick();
    idle();
    chk("sim_c6", 32'(count), 32'd6);
    chk("sim_out0", dout[0], 32'd102);
    chk("sim_out3", dout[3], 32'd210);
    do_pop(3'd4);
    do_pop(3'd1);
    chk("sim_c1", 32'(count), 32'd1);
    do_pop(3'd3);
    chk("clamp_c0", 32'(count), 32'd0);
    chk("clamp_valid", 32'(out_valid), 32'd0);
    do_pop(3'd7);
    chk("empty_pop", 32'(count), 32'd0);

    // flush with same-cycle push and pop
    push_full(32'd300);
    in_valid = 4'b1011;
    for (int i = 0; i < 4; i++) din[i] = 32'(310 + i);
    tick();
    idle();
    chk("fl_c7", 32'(count), 32'd7);
    chk("fl_out3", dout[3], 32'd303);
    in_valid = 4'hF;
    din = '1;
    pop = 3'd2;
    flush = 1'b1;
    tick();
    idle();
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    in_valid = 4'b0001;
    din[0] = 32'h55;
    tick();
    idle();
    chk("fl_again", dout[0], 32'h55);
    do_pop(3'd1);

    // random sparse traffic across pointer wrap
    for (int c = 0; c < 200; c++) begin
      in_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      if ($urandom_range(0, 9) == 0) pop = 3'($urandom_range(0, 7));
      else pop = 3'($urandom_range(0, (c < 100) ? 2 : 4));
      tick();
    end
    idle();

    // asynchronous reset in the middle of traffic
    push_full(32'h1000);
    in_valid = 4'hF;
    pop = 3'd1;
    #2 reset_ = 1'b0;
    #1 reset_literals("mid");
    mq.delete();
    idle();
    @(posedge clk);
    #3 reset_ = 1'b1;
    push_full(32'h2000);
    chk("post_rst_out0", dout[0], 32'h2000);
    for (int c = 0; c < 20; c++) begin
      in_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      pop = 3'($urandom_range(0, 4));
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
